uart_reg_bridge: RTL and testbench
==================================

# uart_reg_bridge

Host-side command bridge on the byte-FIFO side of the `uart` block. It pops command frames from the UART receive FIFO and executes single-byte register reads and writes on a simple register bus. It pushes one response byte per frame into the UART transmit FIFO. This gives a serial link direct access to on-chip control registers.

## Interface
- `DBITS`, 8, byte width; must match the UART `DBITS`.
- `ADDR_W`, 8, register address width; must be ≤ `DBITS`. The address is the low `ADDR_W` bits of the address byte.
- `TIMEOUT_CYCLES`, 131072, idle cycles allowed between bytes of one frame; must be ≥ 2.
- `i_clk`  in  1  clock; one clock domain, shared with `uart`.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_rx_empty`  in  1  UART receive FIFO empty.
- `i_rx_data`  in  DBITS  head byte of the receive FIFO; valid while `i_rx_empty`=0.
- `o_rd_uart`  out  1  pops the receive FIFO head at the clock edge.
- `i_tx_full`  in  1  UART transmit FIFO full.
- `o_wr_uart`  out  1  pushes `o_wr_data` into the transmit FIFO at the clock edge.
- `o_wr_data`  out  DBITS  response byte.
- `o_reg_addr`  out  ADDR_W  register address.
- `o_reg_wdata`  out  DBITS  register write data.
- `o_reg_we`  out  1  one-cycle write strobe.
- `o_reg_re`  out  1  one-cycle read strobe.
- `i_reg_rdata`  in  DBITS  read data; valid the cycle after `o_reg_re`.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.
- `o_err`  out  1  one-cycle pulse on a bad command or a timeout.

## Operation
- Frames:
  - Write: `0x57` ('W'), addr, data. Response `0x4B` ('K').
  - Read: `0x52` ('R'), addr. Response is the register byte.
  - Any other first byte: response `0x3F` ('?') and an `o_err` pulse.
- FSM states: IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_WAIT, SEND.
  - IDLE: on a pop of 'W' or 'R' → GET_ADDR; on a pop of any other byte → SEND with `0x3F`.
  - GET_ADDR: on a pop, latch `o_reg_addr`; → GET_DATA for a write, → REG_RD for a read.
  - GET_DATA: on a pop, latch `o_reg_wdata`; → REG_WR.
  - REG_WR: `o_reg_we`=1 for this cycle only; load `0x4B` into `o_wr_data`; → SEND.
  - REG_RD: `o_reg_re`=1 for this cycle only; → RD_WAIT.
  - RD_WAIT: `o_wr_data` ← `i_reg_rdata`; → SEND.
  - SEND: `o_wr_uart` = ~`i_tx_full`; on the push cycle → IDLE. With `i_tx_full` held high, SEND waits indefinitely and has no timeout.
- Pop rule:
  - `o_rd_uart` = (state ∈ {IDLE, GET_ADDR, GET_DATA}) & ~`i_rx_empty` (combinational).
  - The byte is consumed on the same edge it is popped. At most one pop per cycle.
  - Back-to-back pops are allowed while the FIFO stays non-empty.
- Timeout:
  - A counter clears on every pop and on entry to GET_ADDR.
  - It increments each cycle in GET_ADDR/GET_DATA while `i_rx_empty`=1.
  - When it reaches `TIMEOUT_CYCLES`-1: `o_err` pulses, the partial frame is discarded, the FSM → IDLE, and no response is sent.
- No reads are ever issued for discarded or unknown frames; no register strobes are issued for them either.
- Reset (asynchronous, including mid-frame):
  - State → IDLE; timeout counter → 0.
  - `o_reg_addr`, `o_reg_wdata`, `o_wr_data` → 0.
  - `o_reg_we`, `o_reg_re`, `o_busy`, `o_err` → 0.
  - `o_rd_uart` and `o_wr_uart` are forced to 0 while in reset.

## Timing
- Edges are counted from the edge that pops the final byte of a frame (edge E).
- Write frame: `o_reg_we` is high during cycle E+1. `o_wr_uart` is high during cycle E+2 if `i_tx_full`=0.
- Read frame: `o_reg_re` is high during cycle E+1. `i_reg_rdata` is sampled at the end of cycle E+2. `o_wr_uart` is high during cycle E+3 if `i_tx_full`=0.
- Unknown command: `o_err` is high and `o_wr_uart` may be high during cycle E+1.
- `o_reg_addr`/`o_reg_wdata` stay stable from their latch edge until the next frame overwrites them.
- Minimum frame-to-frame turnaround: the first byte of the next frame can be popped in the cycle after the SEND push.
- `o_busy` rises the cycle after the first pop of a valid command and falls the cycle after the SEND push.

## Test plan
- Write frame: rx FIFO holds `57 12 A5` → exactly one `o_reg_we` pulse with addr `0x12` and wdata `0xA5`; one push of `0x4B`; `o_err` stays 0.
- Read frame: rx FIFO holds `52 34`, register model returns `0x5C` one cycle after `o_reg_re` → one `o_reg_re` pulse with addr `0x34`; one push of `0x5C`; no `o_reg_we`.
- Unknown command: rx FIFO holds `00`, then `52 01` → `0x3F` pushed with one `o_err` pulse and no register strobes; the following read then completes normally.
- Timeout: `TIMEOUT_CYCLES`=64; send `57 12`, then leave the FIFO empty → `o_err` pulses 63 cycles after the `12` pop; no strobes and no push; a subsequent `52 12` works.
- Backpressure: hold `i_tx_full`=1 for 200 cycles during SEND of a read → no `o_wr_uart` while full; exactly one push after release; no further pops until the push.
- Back-to-back and reset: queue `57 01 11 52 01` with the FIFO never empty → responses `4B 11` in order. Separately, assert `i_rst_n`=0 after `57 01` → all outputs return to their reset values; the next `52 01` completes correctly.

Source files
------------

// File: rtl/uart_reg_bridge_if.sv
// Byte-FIFO and register-bus signals shared by
// the UART register bridge and its neighbours.
interface uart_reg_bridge_if #(
  parameter int DBITS  = 8,
  parameter int ADDR_W = 8
);
  logic              i_rx_empty;
  logic [DBITS-1:0]  i_rx_data;
  logic              o_rd_uart;
  logic              i_tx_full;
  logic              o_wr_uart;
  logic [DBITS-1:0]  o_wr_data;
  logic [ADDR_W-1:0] o_reg_addr;
  logic [DBITS-1:0]  o_reg_wdata;
  logic              o_reg_we;
  logic              o_reg_re;
  logic [DBITS-1:0]  i_reg_rdata;
  logic              o_busy;
  logic              o_err;

  modport master (
    input  i_rx_empty,
    input  i_rx_data,
    input  i_tx_full,
    input  i_reg_rdata,
    output o_rd_uart,
    output o_wr_uart,
    output o_wr_data,
    output o_reg_addr,
    output o_reg_wdata,
    output o_reg_we,
    output o_reg_re,
    output o_busy,
    output o_err
  );

  modport slave (
    output i_rx_empty,
    output i_rx_data,
    output i_tx_full,
    output i_reg_rdata,
    input  o_rd_uart,
    input  o_wr_uart,
    input  o_wr_data,
    input  o_reg_addr,
    input  o_reg_wdata,
    input  o_reg_we,
    input  o_reg_re,
    input  o_busy,
    input  o_err
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// Serial command bridge: pops W/R frames from the
// UART rx FIFO, runs register ops, pushes one reply.
module uart_reg_bridge #(
  parameter int DBITS          = 8,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input logic              i_clk,
  input logic              i_rst_n,
  uart_reg_bridge_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(TIMEOUT_CYCLES - 2);

  localparam logic [DBITS-1:0] CMD_W = DBITS'('h57);
  localparam logic [DBITS-1:0] CMD_R = DBITS'('h52);
  localparam logic [DBITS-1:0] ACK   = DBITS'('h4B);
  localparam logic [DBITS-1:0] NAK   = DBITS'('h3F);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    REG_WR,
    REG_RD,
    RD_WAIT,
    SEND
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_n;
  logic [DBITS-1:0]  wdata_q;
  logic [DBITS-1:0]  wdata_n;
  logic [DBITS-1:0]  wr_data_q;
  logic [DBITS-1:0]  wr_data_n;
  logic              is_wr;
  logic              is_wr_n;
  logic              err_q;
  logic              err_n;
  logic              in_get;
  logic              pop;
  logic              push;
  logic              tmo;

  // Pop/push qualifiers; both held low during reset.
  // tmo fires in the cycle the idle count would hit
  // TIMEOUT_CYCLES-1, so the FSM leaves on that edge.
  always_comb begin
    in_get = (state == GET_ADDR) || (state == GET_DATA);
    pop    = i_rst_n && !bus.i_rx_empty &&
             (in_get || (state == IDLE));
    push   = i_rst_n && !bus.i_tx_full &&
             (state == SEND);
    tmo    = in_get && bus.i_rx_empty &&
             (cnt == TMO_LAST);
  end

  // Next-state and next datapath values.
  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    wr_data_n = wr_data_q;
    is_wr_n   = is_wr;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop) begin
          if (bus.i_rx_data == CMD_W ||
              bus.i_rx_data == CMD_R) begin
            is_wr_n = (bus.i_rx_data == CMD_W);
            state_n = GET_ADDR;
          end else begin
            wr_data_n = NAK;
            err_n     = 1'b1;
            state_n   = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (pop) begin
          addr_n  = bus.i_rx_data[ADDR_W-1:0];
          state_n = is_wr ? GET_DATA : REG_RD;
        end else if (tmo) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GET_DATA: begin
        if (pop) begin
          wdata_n = bus.i_rx_data;
          state_n = REG_WR;
        end else if (tmo) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      REG_WR: begin
        wr_data_n = ACK;
        state_n   = SEND;
      end
      REG_RD: begin
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        wr_data_n = bus.i_reg_rdata;
        state_n   = SEND;
      end
      SEND: begin
        if (push) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register and inter-byte idle counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Latched address, write data, reply and flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_data_q <= '0;
      is_wr     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      wr_data_q <= wr_data_n;
      is_wr     <= is_wr_n;
      err_q     <= err_n;
    end
  end

  assign bus.o_rd_uart   = pop;
  assign bus.o_wr_uart   = push;
  assign bus.o_wr_data   = wr_data_q;
  assign bus.o_reg_addr  = addr_q;
  assign bus.o_reg_wdata = wdata_q;
  assign bus.o_reg_we    = (state == REG_WR);
  assign bus.o_reg_re    = (state == REG_RD);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_err       = err_q | tmo;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with FIFO
// and register-file models around the DUT.
module tb_uart_reg_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_reg_bridge_if #(.DBITS(8), .ADDR_W(8)) bus ();

  uart_reg_bridge #(
    .DBITS(8),
    .ADDR_W(8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    int          nb;
    logic [39:0] b;
    int          nr;
    logic [15:0] r;
    int          we;
    int          re;
    int          err;
    logic [7:0]  addr;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int failures = 0;

  logic [7:0] rxq [$];
  logic [7:0] txq [$];
  logic [7:0] regs [256];

  int cyc = 0;
  int pop_cnt, we_cnt, re_cnt, err_cnt;
  int pop_cyc, we_cyc, re_cyc, err_cyc, wr_cyc;
  logic pop_p = 1'b0;
  logic we_p = 1'b0;
  logic re_p = 1'b0;
  logic [7:0] addr_p = '0;
  logic [7:0] wdata_p = '0;
  logic [7:0] rdata_v = '0;

  // Observe outputs mid-cycle.
  always @(negedge clk) begin
    cyc++;
    pop_p   = bus.o_rd_uart;
    we_p    = bus.o_reg_we;
    re_p    = bus.o_reg_re;
    addr_p  = bus.o_reg_addr;
    wdata_p = bus.o_reg_wdata;
    if (bus.o_rd_uart === 1'b1) begin
      pop_cnt++;
      pop_cyc = cyc;
    end
    if (bus.o_reg_we === 1'b1) begin
      we_cnt++;
      we_cyc = cyc;
    end
    if (bus.o_reg_re === 1'b1) begin
      re_cnt++;
      re_cyc = cyc;
    end
    if (bus.o_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.o_wr_uart === 1'b1) begin
      txq.push_back(bus.o_wr_data);
      wr_cyc = cyc;
    end
  end

  // Apply the edge's effects on FIFO and registers.
  always @(posedge clk) begin
    #1;
    if (pop_p === 1'b1 && rxq.size() > 0)
      void'(rxq.pop_front());
    if (we_p === 1'b1) regs[addr_p] = wdata_p;
    if (re_p === 1'b1) rdata_v = regs[addr_p];
    bus.i_reg_rdata = rdata_v;
    bus.i_rx_empty  = (rxq.size() == 0);
    bus.i_rx_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    txq.delete();
    pop_cnt = 0;
    we_cnt  = 0;
    re_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic push_bytes(input logic [39:0] b,
                            input int n);
    for (int i = 0; i < n; i++)
      rxq.push_back(b[8*(n-1-i) +: 8]);
  endtask

  function automatic logic [7:0] tx_at(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  task automatic wait_tx(input int n,
                         input string name);
    int k;
    k = 0;
    while (txq.size() < n && k < 400) begin
      tick(1);
      k++;
    end
    chk(name, 32'(txq.size() >= n), 1);
    tick(5);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctl"},
        {bus.o_rd_uart, bus.o_wr_uart, bus.o_reg_we,
         bus.o_reg_re, bus.o_busy, bus.o_err}, 0);
    chk({name, "_addr"}, bus.o_reg_addr, 0);
    chk({name, "_wdata"}, bus.o_reg_wdata, 0);
    chk({name, "_wrdata"}, bus.o_wr_data, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    regs[8'h34] = 8'h5C;
    regs[8'h01] = 8'h77;
    bus.i_tx_full = 1'b0;

    vecs[0] = '{3, 40'h57_12_A5, 1, 16'h004B,
                1, 0, 0, 8'h12};
    vecs[1] = '{2, 40'h52_34, 1, 16'h005C,
                0, 1, 0, 8'h34};
    vecs[2] = '{3, 40'h00_52_01, 2, 16'h3F77,
                0, 1, 1, 8'h01};
    vecs[3] = '{5, 40'h57_01_11_52_01, 2, 16'h4B11,
                1, 1, 0, 8'h01};
    vecs[4] = '{2, 40'h52_12, 1, 16'h00A5,
                0, 1, 0, 8'h12};

    // Reset holds pops off even with a byte queued.
    tick(3);
    rxq.push_back(8'h52);
    tick(3);
    chk_reset_outs("reset");
    clr();
    @(posedge clk);
    #2 rst_n = 1'b1;
    rxq.push_back(8'h34);
    wait_tx(1, "rel_resp");
    chk("rel_data", tx_at(0), 8'h5C);
    chk("rel_err", err_cnt, 0);

    for (int v = 0; v < 5; v++) begin
      clr();
      push_bytes(vecs[v].b, vecs[v].nb);
      wait_tx(vecs[v].nr, $sformatf("v%0d_resp", v));
      chk($sformatf("v%0d_ntx", v), txq.size(), vecs[v].nr);
      for (int j = 0; j < vecs[v].nr; j++)
        chk($sformatf("v%0d_tx%0d", v, j), tx_at(j),
            vecs[v].r[8*(vecs[v].nr-1-j) +: 8]);
      chk($sformatf("v%0d_we", v), we_cnt, vecs[v].we);
      chk($sformatf("v%0d_re", v), re_cnt, vecs[v].re);
      chk($sformatf("v%0d_err", v), err_cnt, vecs[v].err);
      chk($sformatf("v%0d_addr", v), bus.o_reg_addr,
          vecs[v].addr);
      chk($sformatf("v%0d_busy", v), bus.o_busy, 0);
    end
    chk("v0_wdata_reg", regs[8'h12], 8'hA5);

    // Write frame latency from the last pop.
    clr();
    push_bytes(40'h57_56_9A, 3);
    wait_tx(1, "wt_resp");
    chk("wt_we_lat", we_cyc - pop_cyc, 1);
    chk("wt_push_lat", wr_cyc - pop_cyc, 2);
    chk("wt_wdata", bus.o_reg_wdata, 8'h9A);

    // Read frame latency.
    clr();
    push_bytes(40'h52_56, 2);
    wait_tx(1, "rt_resp");
    chk("rt_re_lat", re_cyc - pop_cyc, 1);
    chk("rt_push_lat", wr_cyc - pop_cyc, 3);
    chk("rt_data", tx_at(0), 8'h9A);

    // Unknown command latency.
    clr();
    push_bytes(40'h41, 1);
    wait_tx(1, "uk_resp");
    chk("uk_err_lat", err_cyc - pop_cyc, 1);
    chk("uk_push_lat", wr_cyc - pop_cyc, 1);
    chk("uk_data", tx_at(0), 8'h3F);
    chk("uk_strobes", we_cnt + re_cnt, 0);

    // Timeout after a partial write frame.
    clr();
    push_bytes(40'h57_12, 2);
    k = 0;
    while (err_cnt == 0 && k < 200) begin
      tick(1);
      k++;
    end
    tick(10);
    chk("tmo_err_cnt", err_cnt, 1);
    chk("tmo_lat", err_cyc - pop_cyc, 63);
    chk("tmo_strobes", we_cnt + re_cnt, 0);
    chk("tmo_no_push", txq.size(), 0);
    chk("tmo_busy", bus.o_busy, 0);
    clr();
    push_bytes(40'h52_12, 2);
    wait_tx(1, "tmo_next_resp");
    chk("tmo_next_data", tx_at(0), 8'hA5);

    // Backpressure: tx full for 200 cycles.
    clr();
    @(posedge clk);
    #2 bus.i_tx_full = 1'b1;
    push_bytes(40'h52_34_52_56, 4);
    tick(200);
    chk("bp_no_push", txq.size(), 0);
    chk("bp_pops", pop_cnt, 2);
    chk("bp_busy", bus.o_busy, 1);
    @(posedge clk);
    #2 bus.i_tx_full = 1'b0;
    wait_tx(2, "bp_resp");
    chk("bp_ntx", txq.size(), 2);
    chk("bp_tx0", tx_at(0), 8'h5C);
    chk("bp_tx1", tx_at(1), 8'h9A);
    chk("bp_pops_all", pop_cnt, 4);

    // Reset in the middle of a write frame.
    clr();
    push_bytes(40'h57_01, 2);
    k = 0;
    while (pop_cnt < 2 && k < 50) begin
      tick(1);
      k++;
    end
    chk("mr_mid_busy", bus.o_busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    tick(1);
    chk_reset_outs("mr");
    tick(2);
    @(posedge clk);
    #2 rst_n = 1'b1;
    push_bytes(40'h52_01, 2);
    wait_tx(1, "mr_resp");
    chk("mr_data", tx_at(0), 8'h11);
    chk("mr_we", we_cnt, 0);
    chk("mr_ntx", txq.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
